// File: rtl/ederah_feeder_pkg.sv
// Shared types and constants for the engine input stream feeder.
package ederah_feeder_pkg;

  localparam int unsigned C_HASH_W = 32;
  localparam int unsigned C_LEN_W  = 32;

  localparam logic TTYPE_NFA = 1'b0;
  localparam logic TTYPE_QRY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_NFA = 2'd1,
    ST_SEND_QRY = 2'd2,
    ST_DRAIN    = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic [C_HASH_W-1:0] hash;
    logic [C_LEN_W-1:0]  nfa_len;
    logic [C_LEN_W-1:0]  qry_len;
    logic                force_nfa;
  } cmd_t;

endpackage

// File: rtl/ederah_axis_skid.sv
// Two-entry register slice for {tdata, tlast, ttype}; ready to the source is a pure register.
module ederah_axis_skid
  import ederah_feeder_pkg::*;
#(
  parameter int unsigned G_DATA_W = 512
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [G_DATA_W-1:0] s_data_i,
  input  logic                s_last_i,
  input  logic                s_type_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [G_DATA_W-1:0] m_data_o,
  output logic                m_last_o,
  output logic                m_type_o
);

  localparam int unsigned C_PAY_W = G_DATA_W + 2;
  localparam logic [C_PAY_W-1:0] C_PAY_RST = {{G_DATA_W{1'b0}}, 1'b0, TTYPE_QRY};

  logic [C_PAY_W-1:0] r_main;
  logic [C_PAY_W-1:0] r_skid;
  logic               r_main_vld;
  logic               r_skid_vld;
  logic [C_PAY_W-1:0] w_in;

  assign w_in = {s_data_i, s_last_i, s_type_i};

  // The skid entry is only ever occupied behind a stalled main entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_main     <= C_PAY_RST;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (r_skid_vld) begin
      if (m_ready_i) begin
        r_main     <= r_skid;
        r_skid_vld <= 1'b0;
      end
    end else if (!r_main_vld || m_ready_i) begin
      r_main_vld <= s_valid_i;
      if (s_valid_i) r_main <= w_in;
    end else if (s_valid_i) begin
      r_skid     <= w_in;
      r_skid_vld <= 1'b1;
    end
  end

  assign s_ready_o = ~r_skid_vld;
  assign m_valid_o = r_main_vld;
  assign {m_data_o, m_last_o, m_type_o} = r_main;

endmodule

// File: rtl/ederah_stream_feeder.sv
// Job-driven NFA/query packet feeder onto the engine input stream.
// Optional FEEDER_STATS_EN adds saturating beat and stall counters.
module ederah_stream_feeder
  import ederah_feeder_pkg::*;
#(
  parameter int unsigned G_DATA_BUS_WIDTH = 512,
  parameter int unsigned G_LEN_WIDTH      = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [31:0]                 cmd_nfa_hash_i,
  input  logic [G_LEN_WIDTH-1:0]      cmd_nfa_len_i,
  input  logic [G_LEN_WIDTH-1:0]      cmd_qry_len_i,
  input  logic                        cmd_force_i,
  input  logic [G_DATA_BUS_WIDTH-1:0] nfa_data_i,
  input  logic                        nfa_valid_i,
  output logic                        nfa_ready_o,
  input  logic [G_DATA_BUS_WIDTH-1:0] qry_data_i,
  input  logic                        qry_valid_i,
  output logic                        qry_ready_o,
  output logic [G_DATA_BUS_WIDTH-1:0] m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  output logic                        m_tlast_o,
  output logic                        m_ttype_o,
  output logic                        busy_o,
  output logic                        done_o
`ifdef FEEDER_STATS_EN
  ,
  output logic [31:0]                 stat_nfa_beats_o,
  output logic [31:0]                 stat_qry_beats_o,
  output logic [31:0]                 stat_stall_o
`endif
);

  localparam int unsigned C_CNT_W = G_LEN_WIDTH + 1;

  feeder_state_t          r_state;
  feeder_state_t          w_state_nxt;
  logic [G_LEN_WIDTH-1:0] r_cnt;
  logic [G_LEN_WIDTH-1:0] r_nfa_len;
  logic [G_LEN_WIDTH-1:0] r_qry_len;
  logic [C_HASH_W-1:0]    r_hash;
  logic                   r_hash_vld;

  cmd_t                        w_cmd;
  logic                        w_cmd_hs;
  logic                        w_send_nfa;
  logic                        w_skid_ready;
  logic                        w_nfa_hs;
  logic                        w_qry_hs;
  logic                        w_nfa_last;
  logic                        w_qry_last;
  logic                        w_drain_done;
  logic                        w_s_valid;
  logic [G_DATA_BUS_WIDTH-1:0] w_s_data;
  logic                        w_s_type;
  logic [G_DATA_BUS_WIDTH-1:0] w_m_data;
  logic                        w_m_valid;
  logic                        w_m_last;
  logic                        w_m_type;
  logic                        w_m_hs;

  always_comb begin
    w_cmd           = '0;
    w_cmd.hash      = cmd_nfa_hash_i;
    w_cmd.nfa_len   = C_LEN_W'(cmd_nfa_len_i);
    w_cmd.qry_len   = C_LEN_W'(cmd_qry_len_i);
    w_cmd.force_nfa = cmd_force_i;
  end

  assign w_cmd_hs   = cmd_valid_i & (r_state == ST_IDLE);
  assign w_send_nfa = (w_cmd.nfa_len != '0) &
                      (w_cmd.force_nfa | ~r_hash_vld | (w_cmd.hash != r_hash));

  assign nfa_ready_o = (r_state == ST_SEND_NFA) & w_skid_ready;
  assign qry_ready_o = (r_state == ST_SEND_QRY) & (r_qry_len != '0) & w_skid_ready;
  assign w_nfa_hs    = nfa_valid_i & nfa_ready_o;
  assign w_qry_hs    = qry_valid_i & qry_ready_o;

  // Terminal index in one extra bit so a zero length cannot alias a real count.
  assign w_nfa_last = w_nfa_hs &
                      ({1'b0, r_cnt} == ({1'b0, r_nfa_len} - C_CNT_W'(1)));
  assign w_qry_last = w_qry_hs &
                      ({1'b0, r_cnt} == ({1'b0, r_qry_len} - C_CNT_W'(1)));

  assign w_m_hs       = w_m_valid & m_tready_i;
  assign w_drain_done = ~w_m_valid | (w_m_hs & w_m_last & (w_m_type == TTYPE_QRY));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_cmd_hs) w_state_nxt = w_send_nfa ? ST_SEND_NFA : ST_SEND_QRY;
      ST_SEND_NFA: if (w_nfa_last) w_state_nxt = ST_SEND_QRY;
      ST_SEND_QRY: if ((r_qry_len == '0) || w_qry_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:    if (w_drain_done) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Beat counter restarts on every phase change; lengths and hash latch on the command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_nfa_len  <= '0;
      r_qry_len  <= '0;
      r_hash     <= '0;
      r_hash_vld <= 1'b0;
    end else begin
      if (w_state_nxt != r_state)  r_cnt <= '0;
      else if (w_nfa_hs | w_qry_hs) r_cnt <= r_cnt + G_LEN_WIDTH'(1);
      if (w_cmd_hs) begin
        r_nfa_len <= w_cmd.nfa_len[G_LEN_WIDTH-1:0];
        r_qry_len <= w_cmd.qry_len[G_LEN_WIDTH-1:0];
        if (w_send_nfa) begin
          r_hash     <= w_cmd.hash;
          r_hash_vld <= 1'b1;
        end
      end
    end
  end

  assign w_s_valid = w_nfa_hs | w_qry_hs;
  assign w_s_data  = (r_state == ST_SEND_NFA) ? nfa_data_i : qry_data_i;
  assign w_s_type  = (r_state == ST_SEND_NFA) ? TTYPE_NFA : TTYPE_QRY;

  ederah_axis_skid #(
    .G_DATA_W (G_DATA_BUS_WIDTH)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (w_s_valid),
    .s_ready_o (w_skid_ready),
    .s_data_i  (w_s_data),
    .s_last_i  (w_nfa_last | w_qry_last),
    .s_type_i  (w_s_type),
    .m_valid_o (w_m_valid),
    .m_ready_i (m_tready_i),
    .m_data_o  (w_m_data),
    .m_last_o  (w_m_last),
    .m_type_o  (w_m_type)
  );

  assign m_tdata_o   = w_m_data;
  assign m_tvalid_o  = w_m_valid;
  assign m_tlast_o   = w_m_last;
  assign m_ttype_o   = w_m_type;
  assign cmd_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DRAIN) & w_drain_done;

`ifdef FEEDER_STATS_EN
  logic [31:0] r_stat_nfa;
  logic [31:0] r_stat_qry;
  logic [31:0] r_stat_stall;

  // Saturating counters of accepted output beats per type and of stalled cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_nfa   <= '0;
      r_stat_qry   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_m_hs && (w_m_type == TTYPE_NFA) && (r_stat_nfa != '1))
        r_stat_nfa <= r_stat_nfa + 32'd1;
      if (w_m_hs && (w_m_type == TTYPE_QRY) && (r_stat_qry != '1))
        r_stat_qry <= r_stat_qry + 32'd1;
      if (w_m_valid && !m_tready_i && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_nfa_beats_o = r_stat_nfa;
  assign stat_qry_beats_o = r_stat_qry;
  assign stat_stall_o     = r_stat_stall;
`endif

endmodule

// File: tb/tb_ederah_stream_feeder.sv
// Directed bench for ederah_stream_feeder: per-beat scoreboard against hand-built packet lists.
module tb_ederah_stream_feeder;

  localparam int unsigned DW = 512;
  localparam int unsigned LW = 32;
  localparam logic [31:0] NFA_TAG = 32'h4E00_0000;
  localparam logic [31:0] QRY_TAG = 32'h5100_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [31:0]   cmd_nfa_hash_i;
  logic [LW-1:0] cmd_nfa_len_i;
  logic [LW-1:0] cmd_qry_len_i;
  logic          cmd_force_i;
  logic [DW-1:0] nfa_data_i;
  logic          nfa_valid_i;
  logic          nfa_ready_o;
  logic [DW-1:0] qry_data_i;
  logic          qry_valid_i;
  logic          qry_ready_o;
  logic [DW-1:0] m_tdata_o;
  logic          m_tvalid_o;
  logic          m_tready_i;
  logic          m_tlast_o;
  logic          m_ttype_o;
  logic          busy_o;
  logic          done_o;
`ifdef FEEDER_STATS_EN
  logic [31:0]   stat_nfa_beats_o;
  logic [31:0]   stat_qry_beats_o;
  logic [31:0]   stat_stall_o;
`endif

  always #5 clk_i = ~clk_i;

  ederah_stream_feeder #(.G_DATA_BUS_WIDTH(DW), .G_LEN_WIDTH(LW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_nfa_hash_i (cmd_nfa_hash_i),
    .cmd_nfa_len_i  (cmd_nfa_len_i),
    .cmd_qry_len_i  (cmd_qry_len_i),
    .cmd_force_i    (cmd_force_i),
    .nfa_data_i     (nfa_data_i),
    .nfa_valid_i    (nfa_valid_i),
    .nfa_ready_o    (nfa_ready_o),
    .qry_data_i     (qry_data_i),
    .qry_valid_i    (qry_valid_i),
    .qry_ready_o    (qry_ready_o),
    .m_tdata_o      (m_tdata_o),
    .m_tvalid_o     (m_tvalid_o),
    .m_tready_i     (m_tready_i),
    .m_tlast_o      (m_tlast_o),
    .m_ttype_o      (m_ttype_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
`ifdef FEEDER_STATS_EN
    ,
    .stat_nfa_beats_o (stat_nfa_beats_o),
    .stat_qry_beats_o (stat_qry_beats_o),
    .stat_stall_o     (stat_stall_o)
`endif
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          nfa_idx = 0;
  int          qry_idx = 0;
  int          done_cnt = 0;
  int          cmd_cnt = 0;
  int          nfa_beats = 0;
  int          qry_beats = 0;
  int          stalls = 0;
  int          hs_cyc = 0;
  int          first_v = -1;
  bit          pat_on = 1'b0;
  bit          cmd_hold = 1'b0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [63:0] beat(input logic [31:0] d, input logic last, input logic typ);
    return {30'd0, last, typ, d};
  endfunction

  // One clock cycle: drive sources, sample away from the edge, score, advance the source models.
  task automatic tick();
    bit nfa_hs, qry_hs, m_hs, cmd_hs;
    m_tready_i  = pat_on ? ((cyc % 2) == 0) : 1'b1;
    nfa_valid_i = pat_on ? (((cyc % 4) == 1) || ((cyc % 4) == 2)) : 1'b1;
    qry_valid_i = 1'b1;
    nfa_data_i  = DW'(NFA_TAG + 32'(nfa_idx));
    qry_data_i  = DW'(QRY_TAG + 32'(qry_idx));
    #1;
    nfa_hs = (nfa_valid_i & nfa_ready_o) === 1'b1;
    qry_hs = (qry_valid_i & qry_ready_o) === 1'b1;
    m_hs   = (m_tvalid_o & m_tready_i) === 1'b1;
    cmd_hs = (cmd_valid_i & cmd_ready_o) === 1'b1;
    if (m_tvalid_o === 1'b1) begin
      if (first_v < 0) first_v = cyc;
      if (exp_q.size() == 0) check("extra_beat", 64'(m_tvalid_o), 64'd0);
      else check("beat", beat(m_tdata_o[31:0], m_tlast_o, m_ttype_o), exp_q[0]);
      if (m_hs && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_hs && m_ttype_o == 1'b0) nfa_beats++;
      if (m_hs && m_ttype_o == 1'b1) qry_beats++;
      if (!m_tready_i) stalls++;
    end
    if (cmd_hs) begin
      cmd_cnt++;
      hs_cyc  = cyc;
      first_v = -1;
    end
    if (done_o === 1'b1) done_cnt++;
    if (nfa_hs) nfa_idx++;
    if (qry_hs) qry_idx++;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (cmd_hs && !cmd_hold) cmd_valid_i = 1'b0;
  endtask

  task automatic load_job(input logic [31:0] hash, input int nl, input int ql,
                          input bit frc, input bit exp_nfa, input bit hold);
    if (exp_nfa)
      for (int i = 0; i < nl; i++)
        exp_q.push_back(beat(NFA_TAG + 32'(nfa_idx + i), (i == nl - 1), 1'b0));
    for (int i = 0; i < ql; i++)
      exp_q.push_back(beat(QRY_TAG + 32'(qry_idx + i), (i == ql - 1), 1'b1));
    cmd_nfa_hash_i = hash;
    cmd_nfa_len_i  = LW'(nl);
    cmd_qry_len_i  = LW'(ql);
    cmd_force_i    = frc;
    cmd_hold       = hold;
    cmd_valid_i    = 1'b1;
  endtask

  task automatic run_job(input logic [31:0] hash, input int nl, input int ql,
                         input bit frc, input bit exp_nfa, input bit hold);
    int d0, c0, nb0, qb0, n, nbeats;
    d0 = done_cnt; c0 = cmd_cnt; nb0 = nfa_beats; qb0 = qry_beats; n = 0;
    nbeats = exp_nfa ? nl : ql;
    load_job(hash, nl, ql, frc, exp_nfa, hold);
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    cmd_valid_i = 1'b0;
    cmd_hold    = 1'b0;
    repeat (3) tick();
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("cmd_once", 64'(cmd_cnt - c0), 64'd1);
    check("nfa_beats", 64'(nfa_beats - nb0), exp_nfa ? 64'(nl) : 64'd0);
    check("qry_beats", 64'(qry_beats - qb0), 64'(ql));
    check("beats_left", 64'(exp_q.size()), 64'd0);
    check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("idle_busy", 64'(busy_o), 64'd0);
    if (!pat_on && nbeats > 0) check("first_beat_latency", 64'(first_v - hs_cyc), 64'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb0, n;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_nfa_hash_i = '0; cmd_nfa_len_i = '0;
    cmd_qry_len_i = '0; cmd_force_i = 1'b0; nfa_data_i = '0; nfa_valid_i = 1'b0;
    qry_data_i = '0; qry_valid_i = 1'b0; m_tready_i = 1'b1;
    @(negedge clk_i);
    repeat (3) tick();
    rst_i = 1'b0;
    done_cnt = 0; nfa_beats = 0; qry_beats = 0; stalls = 0;
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_nfa_ready", 64'(nfa_ready_o), 64'd0);
    check("rst_qry_ready", 64'(qry_ready_o), 64'd0);
    check("rst_tvalid", 64'(m_tvalid_o), 64'd0);
    check("rst_tlast", 64'(m_tlast_o), 64'd0);
    check("rst_ttype", 64'(m_ttype_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);

    run_job(32'hA5, 3, 4, 1'b0, 1'b1, 1'b0);  // first load: NFA + query
    run_job(32'hA5, 3, 4, 1'b0, 1'b0, 1'b0);  // same hash: query only
    run_job(32'hA5, 3, 4, 1'b1, 1'b1, 1'b0);  // forced reload
    run_job(32'h11, 0, 3, 1'b0, 1'b0, 1'b0);  // zero-length NFA skipped
    run_job(32'h11, 0, 0, 1'b0, 1'b0, 1'b0);  // empty job still completes
    run_job(32'hA5, 2, 2, 1'b0, 1'b0, 1'b0);  // hash still A5

    pat_on = 1'b1;
    run_job(32'h22, 5, 5, 1'b0, 1'b1, 1'b0);
    pat_on = 1'b0;

    // Reset after two NFA beats of an A5 reload, then A5 must reload again.
    nb0 = nfa_beats; n = 0;
    load_job(32'hA5, 6, 2, 1'b0, 1'b1, 1'b0);
    while (nfa_beats - nb0 < 2 && n < 100) begin
      tick();
      n++;
    end
    check("pre_rst_beats", 64'(nfa_beats - nb0), 64'd2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    nfa_beats = 0; qry_beats = 0; stalls = 0;
    check("mid_rst_tvalid", 64'(m_tvalid_o), 64'd0);
    check("mid_rst_tlast", 64'(m_tlast_o), 64'd0);
    check("mid_rst_ttype", 64'(m_ttype_o), 64'd1);
    check("mid_rst_nfa_ready", 64'(nfa_ready_o), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    run_job(32'hA5, 2, 2, 1'b0, 1'b1, 1'b0);

    run_job(32'h33, 2, 3, 1'b0, 1'b1, 1'b1);  // cmd_valid held for the whole job
    pat_on = 1'b1;
    run_job(32'h33, 2, 3, 1'b0, 1'b0, 1'b1);
    pat_on = 1'b0;

`ifdef FEEDER_STATS_EN
    check("stat_nfa_beats", 64'(stat_nfa_beats_o), 64'(nfa_beats));
    check("stat_qry_beats", 64'(stat_qry_beats_o), 64'(qry_beats));
    check("stat_stall", 64'(stat_stall_o), 64'(stalls));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
